// File: rtl/sync_delay_aligner_pkg.sv
// Shared constants for the sync delay aligner.
//   - VGA 640x480@60 timing components and their totals
//   - 2-bit lock state encoding
//   - position counter width and a saturating increment helper
package sync_delay_aligner_pkg;

    localparam int HACT = 640;
    localparam int HFP  = 16;
    localparam int HSW  = 96;
    localparam int HBP  = 48;
    localparam int VACT = 480;
    localparam int VFP  = 10;
    localparam int VSW  = 2;
    localparam int VBP  = 33;

    localparam int VGA_HTOTAL = HACT + HFP + HSW + HBP;
    localparam int VGA_VTOTAL = VACT + VFP + VSW + VBP;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Increment a position counter, holding at its maximum value.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + 10'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Sync input sampler with registered rising-edge pulse.
//   I_PCLK  pixel clock
//   I_RST   synchronous active-high reset
//   I_SYNC  raw sync input
//   O_RISE  one-cycle pulse, high the cycle after the first-stage sample
//           sees 1 while the second stage still holds 0
module sync_edge_detect (
    input  logic I_PCLK,
    input  logic I_RST,
    input  logic I_SYNC,
    output logic O_RISE
);

    logic sync_q_r;
    logic sync_q2_r;
    logic rise_r;

    // Two sample stages and the registered edge pulse derived from them.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            sync_q_r  <= 1'b0;
            sync_q2_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync_q_r  <= I_SYNC;
            sync_q2_r <= sync_q_r;
            rise_r    <= sync_q_r & ~sync_q2_r;
        end
    end

    assign O_RISE = rise_r;

endmodule

// File: rtl/sync_delay_aligner.sv
// Locks onto incoming VSYNC/HSYNC cadence and emits a delayed frame-restart
// pulse for the downstream timing generator.
//   I_PCLK     pixel clock (only clock)
//   I_RST      synchronous active-high reset
//   I_VSYNC    vertical sync, active-high
//   I_HSYNC    horizontal sync, active-high
//   O_VRST     one-cycle restart pulse at (DLY_LINES, DLY_PIX) while locked
//   O_LOCKED   high while in the LOCKED state
//   O_HCNT     pixel position since last HSYNC rise (saturating)
//   O_VCNT     line position since last VSYNC rise (saturating)
//   O_ERR_CNT  saturating count of lock losses
module sync_delay_aligner
    import sync_delay_aligner_pkg::*;
#(
    parameter int HTOTAL      = VGA_HTOTAL,
    parameter int VTOTAL      = VGA_VTOTAL,
    parameter int DLY_LINES   = 1,
    parameter int DLY_PIX     = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             I_PCLK,
    input  logic             I_RST,
    input  logic             I_VSYNC,
    input  logic             I_HSYNC,
    output logic             O_VRST,
    output logic             O_LOCKED,
    output logic [CNT_W-1:0] O_HCNT,
    output logic [CNT_W-1:0] O_VCNT,
    output logic [7:0]       O_ERR_CNT
);

    localparam logic [CNT_W-1:0] HEND_C  = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] VEND_C  = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] DLY_L_C = CNT_W'(DLY_LINES);
    localparam logic [CNT_W-1:0] DLY_P_C = CNT_W'(DLY_PIX);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_FRAMES);

    logic             vs_rise_s;
    logic             hs_rise_s;
    logic             line_bad_s;
    logic             frame_good_s;
    logic [3:0]       good_inc_s;
    state_t           state_nx_s;
    logic [3:0]       good_nx_s;
    logic             err_inc_s;

    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;
    logic             frame_bad_r;
    state_t           state_r;
    logic [3:0]       good_cnt_r;
    logic [7:0]       err_cnt_r;
    logic             locked_r;
    logic             vrst_r;

    sync_edge_detect u_vs_edge (
        .I_PCLK (I_PCLK),
        .I_RST  (I_RST),
        .I_SYNC (I_VSYNC),
        .O_RISE (vs_rise_s)
    );

    sync_edge_detect u_hs_edge (
        .I_PCLK (I_PCLK),
        .I_RST  (I_RST),
        .I_SYNC (I_HSYNC),
        .O_RISE (hs_rise_s)
    );

    // A line ending now is bad unless it lasted exactly HTOTAL clocks; the
    // frame verdict folds in a bad line ending in the same cycle as VSYNC.
    assign line_bad_s   = hs_rise_s && (hcnt_r != HEND_C);
    assign frame_good_s = (vcnt_r == VEND_C) && !frame_bad_r && !line_bad_s;
    assign good_inc_s   = good_cnt_r + 4'd1;

    // Lock state machine: next state, good-frame count, lock-loss event.
    always_comb begin
        state_nx_s = state_r;
        good_nx_s  = good_cnt_r;
        err_inc_s  = 1'b0;
        if (vs_rise_s) begin
            case (state_r)
                ST_UNLOCKED: begin
                    // The frame in progress at wake-up is partial; skip it.
                    state_nx_s = ST_MEASURE;
                    good_nx_s  = 4'd0;
                end
                ST_MEASURE: begin
                    if (frame_good_s) begin
                        good_nx_s = good_inc_s;
                        if (good_inc_s == LOCK_C) begin
                            state_nx_s = ST_LOCKED;
                        end else begin
                            state_nx_s = ST_MEASURE;
                        end
                    end else begin
                        good_nx_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good_s) begin
                        state_nx_s = ST_MEASURE;
                        good_nx_s  = 4'd0;
                        err_inc_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nx_s = ST_UNLOCKED;
                    good_nx_s  = 4'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Lock state register, good-frame counter and saturating error counter.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            state_r    <= ST_UNLOCKED;
            good_cnt_r <= 4'd0;
            err_cnt_r  <= 8'd0;
        end else begin
            state_r    <= state_nx_s;
            good_cnt_r <= good_nx_s;
            if (err_inc_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // Pixel/line position counters; VSYNC outranks HSYNC.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (vs_rise_s) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (hs_rise_s) begin
            hcnt_r <= '0;
            vcnt_r <= sat_inc_cnt(vcnt_r);
        end else begin
            hcnt_r <= sat_inc_cnt(hcnt_r);
        end
    end

    // Sticky bad-line flag; cleared once the frame has been judged.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            frame_bad_r <= 1'b0;
        end else if (vs_rise_s) begin
            frame_bad_r <= 1'b0;
        end else if (line_bad_s) begin
            frame_bad_r <= 1'b1;
        end
    end

    // Registered status and restart pulse outputs.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            locked_r <= 1'b0;
            vrst_r   <= 1'b0;
        end else begin
            // Track the state register exactly, hence the next-state source.
            locked_r <= (state_nx_s == ST_LOCKED);
            vrst_r   <= (state_r == ST_LOCKED) && (vcnt_r == DLY_L_C) &&
                        (hcnt_r == DLY_P_C);
        end
    end

    assign O_VRST    = vrst_r;
    assign O_LOCKED  = locked_r;
    assign O_HCNT    = hcnt_r;
    assign O_VCNT    = vcnt_r;
    assign O_ERR_CNT = err_cnt_r;

endmodule
